// File: rtl/otbn_otp_key_requester.sv
// OTBN-side initiator of the OTBN/OTP key handshake.
// Issues req, waits for ack, and captures key/nonce on a valid seed.
// It also handles per-attempt timeout, bounded retry with a one-cycle
// backoff, secure wipe and a sticky error.
module otbn_otp_key_requester #(
  parameter int unsigned KeyWidth      = 128,
  parameter int unsigned NonceWidth    = 64,
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned MaxRetries    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  wipe_i,
  output logic                  otp_req_o,
  input  logic                  otp_ack_i,
  input  logic [KeyWidth-1:0]   otp_key_i,
  input  logic [NonceWidth-1:0] otp_nonce_i,
  input  logic                  otp_seed_valid_i,
  output logic [KeyWidth-1:0]   key_o,
  output logic [NonceWidth-1:0] nonce_o,
  output logic                  key_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  spurious_ack_o
);

  localparam int unsigned TW = $clog2(TimeoutCycles);
  localparam int unsigned RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TimeoutCycles - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MaxRetries);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_BACKOFF = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  logic [2:0]    state_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;

  // FSM, counters and all registered outputs. Wipe beats start and ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tmo_q          <= '0;
      retry_q        <= '0;
      otp_req_o      <= 1'b0;
      key_o          <= '0;
      nonce_o        <= '0;
      key_valid_o    <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      spurious_ack_o <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      spurious_ack_o <= 1'b0;
      if (wipe_i) begin
        state_q     <= ST_IDLE;
        tmo_q       <= '0;
        retry_q     <= '0;
        otp_req_o   <= 1'b0;
        key_o       <= '0;
        nonce_o     <= '0;
        key_valid_o <= 1'b0;
        busy_o      <= 1'b0;
        err_o       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (otp_ack_i) spurious_ack_o <= 1'b1;
            if (start_i) begin
              state_q     <= ST_REQ;
              tmo_q       <= '0;
              retry_q     <= '0;
              otp_req_o   <= 1'b1;
              key_valid_o <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
          ST_REQ: begin
            if (otp_ack_i && otp_seed_valid_i) begin
              state_q     <= ST_DONE;
              key_o       <= otp_key_i;
              nonce_o     <= otp_nonce_i;
              key_valid_o <= 1'b1;
              done_o      <= 1'b1;
              otp_req_o   <= 1'b0;
              busy_o      <= 1'b0;
            end else if (otp_ack_i || (tmo_q == TMO_LAST)) begin
              // Failed attempt: bad seed or timeout.
              otp_req_o <= 1'b0;
              if (retry_q < RETRY_MAX) begin
                state_q <= ST_BACKOFF;
                retry_q <= retry_q + 1'b1;
              end else begin
                state_q <= ST_ERROR;
                err_o   <= 1'b1;
                busy_o  <= 1'b0;
              end
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ST_BACKOFF: begin
            // A late good ack is still accepted; a late bad one is dropped.
            if (otp_ack_i && otp_seed_valid_i) begin
              state_q     <= ST_DONE;
              key_o       <= otp_key_i;
              nonce_o     <= otp_nonce_i;
              key_valid_o <= 1'b1;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              state_q   <= ST_REQ;
              tmo_q     <= '0;
              otp_req_o <= 1'b1;
            end
          end
          ST_ERROR: begin
            if (otp_ack_i) spurious_ack_o <= 1'b1;
          end
          default: begin
            state_q   <= ST_IDLE;
            otp_req_o <= 1'b0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_otbn_otp_key_requester.sv
// Directed self-checking bench for otbn_otp_key_requester.
module tb_otbn_otp_key_requester;

  localparam int KW = 128;
  localparam int NW = 64;

  localparam logic [KW-1:0] K1  = 128'h4235171482c225f79289b32181a0163a;
  localparam logic [KW-1:0] K2  = 128'h4235171482c225f79289b32181a0163b;
  localparam logic [KW-1:0] K3  = 128'h4235171482c225f79289b32181a0163c;
  localparam logic [KW-1:0] KB  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [NW-1:0] N1  = 64'h760355d3447063d1;
  localparam logic [NW-1:0] N2  = 64'h760355d3447063d2;
  localparam logic [NW-1:0] N3  = 64'h760355d3447063d3;
  localparam logic [NW-1:0] NB  = 64'h0badf00d0badf00d;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, wipe_i, otp_ack_i, otp_seed_valid_i;
  logic [KW-1:0] otp_key_i, key_o;
  logic [NW-1:0] otp_nonce_i, nonce_o;
  logic          otp_req_o, key_valid_o, busy_o, done_o, err_o, spurious_ack_o;

  int cmp = 0;
  int mis = 0;
  int spur_cnt = 0;

  otbn_otp_key_requester #(
    .KeyWidth(KW), .NonceWidth(NW), .TimeoutCycles(64), .MaxRetries(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .wipe_i(wipe_i),
    .otp_req_o(otp_req_o), .otp_ack_i(otp_ack_i), .otp_key_i(otp_key_i),
    .otp_nonce_i(otp_nonce_i), .otp_seed_valid_i(otp_seed_valid_i),
    .key_o(key_o), .nonce_o(nonce_o), .key_valid_o(key_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .spurious_ack_o(spurious_ack_o)
  );

  always #5 clk = ~clk;

  // Count spurious-ack pulses sampled mid-cycle.
  always @(negedge clk) if (spurious_ack_o === 1'b1) spur_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [KW-1:0] k, input logic [NW-1:0] n, input logic sv);
    otp_ack_i = 1'b1; otp_key_i = k; otp_nonce_i = n; otp_seed_valid_i = sv;
  endtask

  task automatic unack;
    otp_ack_i = 1'b0; otp_seed_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    cmp++; if (otp_req_o !== 1'b0) begin mis++; $display("FAIL rst_req got %b want 0", otp_req_o); end
    cmp++; if (key_o !== '0) begin mis++; $display("FAIL rst_key got %h want 0", key_o); end
    cmp++; if (nonce_o !== '0) begin mis++; $display("FAIL rst_nonce got %h want 0", nonce_o); end
    cmp++; if ({key_valid_o, busy_o, done_o, err_o, spurious_ack_o} !== 5'b0) begin
      mis++; $display("FAIL rst_flags got %b want 00000", {key_valid_o, busy_o, done_o, err_o, spurious_ack_o});
    end
  endtask

  task automatic test_nominal;
    start_i = 1'b1; tick; start_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cmp++; if (otp_req_o !== 1'b1) begin mis++; $display("FAIL nom_req_c%0d got %b want 1", c, otp_req_o); end
      if (c == 3) ack(K1, N1, 1'b1);
      tick;
    end
    unack;
    cmp++; if (key_o !== K1) begin mis++; $display("FAIL nom_key got %h want %h", key_o, K1); end
    cmp++; if (nonce_o !== N1) begin mis++; $display("FAIL nom_nonce got %h want %h", nonce_o, N1); end
    cmp++; if ({key_valid_o, done_o, otp_req_o, busy_o} !== 4'b1100) begin
      mis++; $display("FAIL nom_flags got %b want 1100", {key_valid_o, done_o, otp_req_o, busy_o});
    end
    tick;
    cmp++; if (done_o !== 1'b0) begin mis++; $display("FAIL nom_done_pulse got %b want 0", done_o); end
  endtask

  task automatic test_back_to_back;
    int base;
    base = spur_cnt;
    start_i = 1'b1; tick; start_i = 1'b0;
    cmp++; if ({key_valid_o, otp_req_o} !== 2'b01) begin mis++; $display("FAIL b2b_start got %b want 01", {key_valid_o, otp_req_o}); end
    cmp++; if (key_o !== K1) begin mis++; $display("FAIL b2b_oldkey got %h want %h", key_o, K1); end
    tick;
    cmp++; if (key_valid_o !== 1'b0) begin mis++; $display("FAIL b2b_valid_low got %b want 0", key_valid_o); end
    ack(K2, N2, 1'b1); tick; unack;
    cmp++; if (key_o !== K2 || nonce_o !== N2) begin mis++; $display("FAIL b2b_key got %h/%h want %h/%h", key_o, nonce_o, K2, N2); end
    cmp++; if ({key_valid_o, done_o, otp_req_o} !== 3'b110) begin mis++; $display("FAIL b2b_flags got %b want 110", {key_valid_o, done_o, otp_req_o}); end
    tick;
    cmp++; if (otp_req_o !== 1'b0) begin mis++; $display("FAIL b2b_req_stays_low got %b want 0", otp_req_o); end
    cmp++; if (spur_cnt !== base) begin mis++; $display("FAIL b2b_spurious got %0d want %0d", spur_cnt, base); end
  endtask

  task automatic test_bad_seed;
    start_i = 1'b1; tick; start_i = 1'b0;
    ack(KB, NB, 1'b0); tick; unack;
    cmp++; if ({otp_req_o, busy_o, key_valid_o, done_o} !== 4'b0100) begin
      mis++; $display("FAIL bad_backoff got %b want 0100", {otp_req_o, busy_o, key_valid_o, done_o});
    end
    cmp++; if (key_o !== K2) begin mis++; $display("FAIL bad_nocapture got %h want %h", key_o, K2); end
    tick;
    cmp++; if (otp_req_o !== 1'b1) begin mis++; $display("FAIL bad_rereq got %b want 1", otp_req_o); end
    ack(K3, N3, 1'b1); tick; unack;
    cmp++; if (key_o !== K3 || nonce_o !== N3) begin mis++; $display("FAIL bad_key got %h/%h want %h/%h", key_o, nonce_o, K3, N3); end
    cmp++; if ({done_o, err_o, key_valid_o} !== 3'b101) begin mis++; $display("FAIL bad_flags got %b want 101", {done_o, err_o, key_valid_o}); end
  endtask

  task automatic test_spurious;
    tick;
    ack(KB, NB, 1'b1); tick; unack;
    cmp++; if (spurious_ack_o !== 1'b1) begin mis++; $display("FAIL spur_pulse got %b want 1", spurious_ack_o); end
    cmp++; if (key_o !== K3) begin mis++; $display("FAIL spur_key got %h want %h", key_o, K3); end
    tick;
    cmp++; if (spurious_ack_o !== 1'b0) begin mis++; $display("FAIL spur_one_cycle got %b want 0", spurious_ack_o); end
  endtask

  task automatic test_timeout_retry;
    int n;
    start_i = 1'b1; tick; start_i = 1'b0;
    for (int w = 0; w < 3; w++) begin
      n = 0;
      while (otp_req_o === 1'b1 && n < 200) begin n++; tick; end
      cmp++; if (n != 64) begin mis++; $display("FAIL tmo_window%0d got %0d want 64", w, n); end
      if (w < 2) begin
        cmp++; if ({otp_req_o, busy_o, err_o} !== 3'b010) begin mis++; $display("FAIL tmo_backoff%0d got %b want 010", w, {otp_req_o, busy_o, err_o}); end
        tick;
      end
    end
    cmp++; if ({err_o, busy_o, key_valid_o, otp_req_o} !== 4'b1000) begin
      mis++; $display("FAIL tmo_error got %b want 1000", {err_o, busy_o, key_valid_o, otp_req_o});
    end
    start_i = 1'b1; tick; start_i = 1'b0; tick;
    cmp++; if ({otp_req_o, err_o} !== 2'b01) begin mis++; $display("FAIL tmo_start_ignored got %b want 01", {otp_req_o, err_o}); end
  endtask

  task automatic test_wipe_priority;
    wipe_i = 1'b1; tick; wipe_i = 1'b0;
    cmp++; if ({err_o, busy_o, otp_req_o} !== 3'b000) begin mis++; $display("FAIL wipe_err got %b want 000", {err_o, busy_o, otp_req_o}); end
    cmp++; if (key_o !== '0) begin mis++; $display("FAIL wipe_key got %h want 0", key_o); end
    start_i = 1'b1; tick; start_i = 1'b0;
    ack(K1, N1, 1'b1); tick; unack;
    cmp++; if (key_o !== K1) begin mis++; $display("FAIL wipe_refetch got %h want %h", key_o, K1); end
    start_i = 1'b1; tick; start_i = 1'b0;
    wipe_i = 1'b1; start_i = 1'b1; ack(K2, N2, 1'b1); tick;
    wipe_i = 1'b0; start_i = 1'b0; unack;
    cmp++; if (key_o !== '0 || nonce_o !== '0) begin mis++; $display("FAIL wipe_prio_data got %h/%h want 0/0", key_o, nonce_o); end
    cmp++; if ({key_valid_o, otp_req_o, done_o, busy_o} !== 4'b0000) begin
      mis++; $display("FAIL wipe_prio_flags got %b want 0000", {key_valid_o, otp_req_o, done_o, busy_o});
    end
    tick;
    cmp++; if (otp_req_o !== 1'b0) begin mis++; $display("FAIL wipe_idle got %b want 0", otp_req_o); end
  endtask

  task automatic test_reset_mid_req;
    start_i = 1'b1; tick; start_i = 1'b0;
    ack(K2, N2, 1'b1); tick; unack;
    start_i = 1'b1; tick; start_i = 1'b0; tick;
    cmp++; if (otp_req_o !== 1'b1) begin mis++; $display("FAIL rmid_req_before got %b want 1", otp_req_o); end
    #2 rst_n = 1'b0;
    #1;
    cmp++; if (otp_req_o !== 1'b0) begin mis++; $display("FAIL rmid_req_async got %b want 0", otp_req_o); end
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    tick;
    cmp++; if ({otp_req_o, key_valid_o} !== 2'b00) begin mis++; $display("FAIL rmid_after got %b want 00", {otp_req_o, key_valid_o}); end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; wipe_i = 1'b0;
    otp_ack_i = 1'b0; otp_seed_valid_i = 1'b0; otp_key_i = '0; otp_nonce_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_nominal;
    test_back_to_back;
    test_bad_seed;
    test_spurious;
    test_timeout_retry;
    test_wipe_priority;
    test_reset_mid_req;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule

// File: doc/otbn_otp_key_requester.md
Name: otbn_otp_key_requester

Overview:
- OTBN-side initiator of the OTBN/OTP key handshake. On a start command it raises req, waits for ack from the OTP key responder, and captures key, nonce and seed_valid into holding registers for OTBN's scrambling logic.
- Adds per-attempt timeout, bounded retry, rejection of invalid seeds, secure wipe and a sticky error.
- Sits between OTBN start/stop control and the OTP key port.

Parameters:
- KeyWidth, 128, key bus width.
- NonceWidth, 64, nonce bus width.
- TimeoutCycles, 64, cycles in REQ without ack before an attempt fails (>=2).
- MaxRetries, 2, extra attempts after the first failure; total attempts = MaxRetries+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  request fresh key/nonce; honoured only in IDLE or DONE.
- wipe_i  in  1  clear captured material, abort any fetch, clear error.
- otp_req_o  out  1  request to the OTP key responder.
- otp_ack_i  in  1  one-cycle ack from the responder; key/nonce/seed_valid are valid in that cycle.
- otp_key_i  in  KeyWidth  key from the responder.
- otp_nonce_i  in  NonceWidth  nonce from the responder.
- otp_seed_valid_i  in  1  responder seed-valid flag.
- key_o  out  KeyWidth  captured key.
- nonce_o  out  NonceWidth  captured nonce.
- key_valid_o  out  1  key_o and nonce_o hold a successfully fetched pair.
- busy_o  out  1  state is REQ or BACKOFF.
- done_o  out  1  one-cycle pulse on successful capture.
- err_o  out  1  sticky: all attempts failed.
- spurious_ack_o  out  1  one-cycle pulse: ack received while not requesting.

Behaviour:
- Reset values: all outputs 0; key_o = 0 and nonce_o = 0; state IDLE; timeout counter and retry counter 0.
- All outputs are registered.
- States: IDLE, REQ, BACKOFF, DONE, ERROR.
- IDLE/DONE, start_i=1 (wipe_i=0):
  - Next state REQ; otp_req_o=1 from the next cycle.
  - key_valid_o=0 from the next cycle; key_o and nonce_o keep their old contents until overwritten.
  - Timeout counter cleared; retry counter cleared.
- REQ, otp_ack_i=1 and otp_seed_valid_i=1:
  - key_o and nonce_o load otp_key_i and otp_nonce_i.
  - Next cycle: key_valid_o=1, done_o=1 for one cycle, otp_req_o=0, state DONE.
- REQ, otp_ack_i=1 and otp_seed_valid_i=0: failed attempt. Nothing is captured; handled as a failure (see below).
- REQ, no ack, timeout counter = TimeoutCycles-1: failed attempt. The counter increments once per REQ cycle.
- On a failed attempt:
  - If retry counter < MaxRetries: increment the retry counter, go to BACKOFF, otp_req_o=0.
  - Otherwise: go to ERROR, otp_req_o=0, err_o=1.
- BACKOFF: lasts exactly 1 cycle with otp_req_o low, so the responder's edge detection re-arms. Then REQ with the timeout counter cleared and otp_req_o=1.
- Ack in BACKOFF with seed_valid=1: the late ack is accepted as success. Capture as in REQ, go to DONE, do not re-request.
- Ack in BACKOFF with seed_valid=0: ignored; BACKOFF continues.
- Ack in IDLE, DONE or ERROR: ignored, no capture; spurious_ack_o pulses for one cycle.
- Once DONE is reached, otp_req_o stays low until the next start. The requester never holds req high across an ack, so the responder issues one ack per request.
- ERROR: err_o stays high; start_i is ignored; only wipe_i or reset exits.
- wipe_i=1, any state; it has priority over start_i and otp_ack_i in the same cycle. Next cycle:
  - key_o=0, nonce_o=0, key_valid_o=0, err_o=0, otp_req_o=0.
  - State IDLE; both counters cleared.
- start_i while busy_o=1: ignored.
- Reset mid-fetch: otp_req_o drops asynchronously; no capture.
- Counter widths: $clog2(TimeoutCycles) for the timeout counter and $clog2(MaxRetries+1) for the retry counter. Neither counter wraps; both saturate by state transition.

Test Plan:
- Nominal fetch: start pulse at cycle 0; responder model acks at cycle 3 with key 0x4235171482c225f79289b32181a0163a, nonce 0x760355d3447063d1, seed_valid=1 -> otp_req_o high cycles 1-3; cycle 4 shows key_o/nonce_o equal to those values, key_valid_o=1, done_o=1 for one cycle, otp_req_o=0.
- Back-to-back fetches: second start after DONE -> key_valid_o low until the second ack; captured key is 0x...163b (responder increment); exactly one ack per request, spurious_ack_o never pulses.
- Timeout and retry: responder silent, TimeoutCycles=64, MaxRetries=2 -> three REQ windows of 64 cycles each, each followed by 1 low BACKOFF cycle; after the third window err_o=1, state ERROR, key_valid_o=0; a later start_i is ignored.
- Bad seed: first ack has seed_valid=0, second attempt acks with seed_valid=1 -> first data is not captured, BACKOFF of 1 cycle, second data captured, done_o=1, err_o=0.
- Wipe priority: wipe_i, start_i and otp_ack_i all asserted in the same cycle during REQ -> next cycle key_o=0, nonce_o=0, key_valid_o=0, otp_req_o=0, state IDLE; wipe_i also clears a prior err_o.
- Spurious ack and reset: ack in IDLE -> spurious_ack_o pulses, key_o unchanged; rst_n asserted mid-REQ -> otp_req_o=0 immediately, all outputs return to reset values.
